// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder:
// access-size and FSM-state enums, the latency ceiling and the wait-counter width.
package data_mem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned LATENCY_MAX = 15;
   localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic for one 64-bit memory word: alignment check,
// store byte-merge (mask plus merged word) and load extract with sign/zero extension.
// The offset is always force-aligned to the access size here; the top level
// decides whether a misaligned access is trapped instead.
module mem_lane_align
   import data_mem_pkg::*;
(
   input  logic [2:0]  i_offset,
   input  size_e       i_size,
   input  logic        i_unsigned,
   input  logic [63:0] i_wdata,
   input  logic [63:0] i_old_word,
   output logic [63:0] o_merged,
   output logic [63:0] o_load,
   output logic        o_misaligned
);

   logic [2:0]  w_low_mask;
   logic [2:0]  w_off;
   logic [7:0]  w_width_mask;
   logic [7:0]  w_byte_mask;
   logic [63:0] w_wshift;
   logic [63:0] w_rshift;

   // Size-dependent masks, aligned offset and the addressed byte lanes
   always_comb begin
      w_low_mask   = 3'b000;
      w_width_mask = 8'h01;
      case (i_size)
         SZ_B: begin w_low_mask = 3'b000; w_width_mask = 8'h01; end
         SZ_H: begin w_low_mask = 3'b001; w_width_mask = 8'h03; end
         SZ_W: begin w_low_mask = 3'b011; w_width_mask = 8'h0F; end
         SZ_D: begin w_low_mask = 3'b111; w_width_mask = 8'hFF; end
         default: begin w_low_mask = 3'b000; w_width_mask = 8'h01; end
      endcase
      o_misaligned = |(i_offset & w_low_mask);
      w_off        = i_offset & ~w_low_mask;
      w_byte_mask  = w_width_mask << w_off;
      w_wshift     = i_wdata << {w_off, 3'b000};
      w_rshift     = i_old_word >> {w_off, 3'b000};
   end

   // Store merge: replace only the addressed bytes, keep the rest of the word
   always_comb begin
      o_merged = i_old_word;
      for (int unsigned i = 0; i < 8; i++) begin
         if (w_byte_mask[i]) begin
            o_merged[8*i +: 8] = w_wshift[8*i +: 8];
         end
      end
   end

   // Load extract and extend; a doubleword load ignores the unsigned flag
   always_comb begin
      o_load = '0;
      case (i_size)
         SZ_B: o_load = i_unsigned ? {56'b0, w_rshift[7:0]}
                                   : {{56{w_rshift[7]}}, w_rshift[7:0]};
         SZ_H: o_load = i_unsigned ? {48'b0, w_rshift[15:0]}
                                   : {{48{w_rshift[15]}}, w_rshift[15:0]};
         SZ_W: o_load = i_unsigned ? {32'b0, w_rshift[31:0]}
                                   : {{32{w_rshift[31]}}, w_rshift[31:0]};
         SZ_D: o_load = w_rshift;
         default: o_load = w_rshift;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port: one request at a time over
// valid/ready, fixed LATENCY from accept to response, 64-bit word array with
// byte-lane stores and sized/extended loads.
// Optional: define DATA_MEM_RESPONDER_MISALIGN_TRAP_EN to flag misaligned
// accesses on o_resp_err (no write, zero data) instead of force-aligning them.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_write,
   input  logic [63:0] i_req_addr,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   input  logic [63:0] i_req_wdata,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [63:0] o_resp_rdata,
   output logic        o_resp_err
);

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_INIT = (LATENCY > 1) ? (LATENCY - 2) : 0;

   state_e            r_state;
   state_e            w_next;
   logic [CNT_W-1:0]  r_cnt;

   logic              r_write;
   logic [IDX_W-1:0]  r_idx;
   logic [2:0]        r_off;
   size_e             r_size;
   logic              r_unsigned;
   logic [63:0]       r_wdata;

   logic [63:0]       r_mem [DEPTH_WORDS] = '{default: '0};

   logic [63:0]       r_resp_rdata;
   logic              r_resp_err;

   logic              w_accept;
   logic              w_commit;
   logic              w_cur_write;
   logic [IDX_W-1:0]  w_cur_idx;
   logic [2:0]        w_cur_off;
   size_e             w_cur_size;
   logic              w_cur_unsigned;
   logic [63:0]       w_cur_wdata;
   logic [63:0]       w_old;
   logic [63:0]       w_merged;
   logic [63:0]       w_load;
   logic              w_misaligned;
   logic              w_err;
   logic              w_unused_addr;

   assign w_accept      = (r_state == IDLE) && i_req_valid;
   assign w_commit      = (w_next == RESP) && (r_state != RESP);
   assign w_unused_addr = ^i_req_addr[63:IDX_W+3];

   // With LATENCY=1 the commit happens on the accept edge itself, before the
   // capture registers load, so in IDLE the datapath reads the request directly.
   assign w_cur_write    = (r_state == IDLE) ? i_req_write                 : r_write;
   assign w_cur_idx      = (r_state == IDLE) ? i_req_addr[3 +: IDX_W]      : r_idx;
   assign w_cur_off      = (r_state == IDLE) ? i_req_addr[2:0]             : r_off;
   assign w_cur_size     = (r_state == IDLE) ? size_e'(i_req_size)         : r_size;
   assign w_cur_unsigned = (r_state == IDLE) ? i_req_unsigned              : r_unsigned;
   assign w_cur_wdata    = (r_state == IDLE) ? i_req_wdata                 : r_wdata;

   assign w_old = r_mem[w_cur_idx];

   mem_lane_align u_lane (
      .i_offset     (w_cur_off),
      .i_size       (w_cur_size),
      .i_unsigned   (w_cur_unsigned),
      .i_wdata      (w_cur_wdata),
      .i_old_word   (w_old),
      .o_merged     (w_merged),
      .o_load       (w_load),
      .o_misaligned (w_misaligned)
   );

`ifdef DATA_MEM_RESPONDER_MISALIGN_TRAP_EN
   assign w_err = w_misaligned;
`else
   logic w_unused_misaligned;
   assign w_unused_misaligned = w_misaligned;
   assign w_err = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (i_req_valid)  w_next = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (r_cnt == '0)  w_next = RESP;
         RESP: if (i_resp_ready) w_next = IDLE;
         default:                w_next = IDLE;
      endcase
   end

   // Outputs decoded from state and the registered response
   always_comb begin
      o_req_ready  = (r_state == IDLE);
      o_resp_valid = (r_state == RESP);
      o_resp_rdata = r_resp_rdata;
      o_resp_err   = r_resp_err;
   end

   // Latency down-counter: loaded on accept, counts down while waiting
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= CNT_W'(CNT_INIT);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Request capture on the accept edge only
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_write    <= 1'b0;
         r_idx      <= '0;
         r_off      <= '0;
         r_size     <= SZ_B;
         r_unsigned <= 1'b0;
         r_wdata    <= '0;
      end else if (w_accept) begin
         r_write    <= i_req_write;
         r_idx      <= i_req_addr[3 +: IDX_W];
         r_off      <= i_req_addr[2:0];
         r_size     <= size_e'(i_req_size);
         r_unsigned <= i_req_unsigned;
         r_wdata    <= i_req_wdata;
      end
   end

   // Array write at commit; reset is gated in so a LATENCY=1 accept seen
   // during reset cannot slip a store into the array
   always_ff @(posedge clock) begin
      if (w_commit && w_cur_write && !w_err && !reset) begin
         r_mem[w_cur_idx] <= w_merged;
      end
   end

   // Response registers loaded at commit and held through RESP
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else if (w_commit) begin
         r_resp_rdata <= (w_cur_write || w_err) ? '0 : w_load;
         r_resp_err   <= w_err;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=3 instance for the main
// sequence, LATENCY=4 instance for the reset-in-WAIT case. Expected results
// are queued on accept and popped at the response handshake.
module tb_data_mem_responder;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sel4  = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [63:0] req_addr  = '0;
   logic [1:0]  req_size  = '0;
   logic        req_unsigned = 1'b0;
   logic [63:0] req_wdata = '0;
   logic        resp_ready = 1'b0;

   logic        a_req_ready, a_resp_valid, a_resp_err;
   logic [63:0] a_resp_rdata;
   logic        b_req_ready, b_resp_valid, b_resp_err;
   logic [63:0] b_resp_rdata;

   logic        obs_req_ready, obs_resp_valid, obs_resp_err;
   logic [63:0] obs_resp_rdata;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        sb[$];
   logic        mon_en = 1'b0;
   logic        seen   = 1'b0;

   always #5 clock = ~clock;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut (
      .clock(clock), .reset(reset),
      .i_req_valid(req_valid & ~sel4), .o_req_ready(a_req_ready),
      .i_req_write(req_write), .i_req_addr(req_addr), .i_req_size(req_size),
      .i_req_unsigned(req_unsigned), .i_req_wdata(req_wdata),
      .o_resp_valid(a_resp_valid), .i_resp_ready(resp_ready),
      .o_resp_rdata(a_resp_rdata), .o_resp_err(a_resp_err)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut4 (
      .clock(clock), .reset(reset),
      .i_req_valid(req_valid & sel4), .o_req_ready(b_req_ready),
      .i_req_write(req_write), .i_req_addr(req_addr), .i_req_size(req_size),
      .i_req_unsigned(req_unsigned), .i_req_wdata(req_wdata),
      .o_resp_valid(b_resp_valid), .i_resp_ready(resp_ready),
      .o_resp_rdata(b_resp_rdata), .o_resp_err(b_resp_err)
   );

   assign obs_req_ready  = sel4 ? b_req_ready  : a_req_ready;
   assign obs_resp_valid = sel4 ? b_resp_valid : a_resp_valid;
   assign obs_resp_rdata = sel4 ? b_resp_rdata : a_resp_rdata;
   assign obs_resp_err   = sel4 ? b_resp_err   : a_resp_err;

   always @(negedge clock) begin
      if (mon_en && b_resp_valid) seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input string tag, input logic wr, input logic [63:0] addr,
                         input logic [1:0] size, input logic uns, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input logic exp_err, input int unsigned hold);
      int unsigned lat;
      int unsigned n;
      exp_t        e;
      lat = sel4 ? 4 : 3;
      @(negedge clock);
      check({tag, " req_ready idle"}, 64'(obs_req_ready), 64'd1);
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wd;
      @(posedge clock); #1;
      e.rdata = exp_rd; e.err = exp_err;
      sb.push_back(e);
      // scramble request lines: only the accept edge may matter
      req_valid = 1'b0; req_write = 1'($urandom); req_addr = {$urandom, $urandom};
      req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = {$urandom, $urandom};
      n = 0;
      while (n < 20) begin
         @(negedge clock);
         if (obs_resp_valid) break;
         check({tag, " req_ready busy"}, 64'(obs_req_ready), 64'd0);
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'(lat - 1));
      for (int unsigned h = 0; h < hold; h++) begin
         resp_ready = 1'b0;
         @(negedge clock);
         check({tag, " hold valid"}, 64'(obs_resp_valid), 64'd1);
         check({tag, " hold rdata"}, obs_resp_rdata, sb[0].rdata);
         check({tag, " hold req_ready"}, 64'(obs_req_ready), 64'd0);
      end
      e = sb.pop_front();
      check({tag, " resp_valid"}, 64'(obs_resp_valid), 64'd1);
      check({tag, " rdata"}, obs_resp_rdata, e.rdata);
      check({tag, " err"}, 64'(obs_resp_err), 64'(e.err));
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      @(negedge clock);
      check({tag, " post valid"}, 64'(obs_resp_valid), 64'd0);
      check({tag, " post req_ready"}, 64'(obs_req_ready), 64'd1);
   endtask

   initial begin
      logic exp_err_mis;
      logic [63:0] exp_mis_ld, exp_mis_word;
`ifdef DATA_MEM_RESPONDER_MISALIGN_TRAP_EN
      exp_err_mis  = 1'b1;
      exp_mis_ld   = 64'h0;
      exp_mis_word = 64'h0;
`else
      exp_err_mis  = 1'b0;
      exp_mis_ld   = 64'h0000_0000_1234_5678;
      exp_mis_word = 64'h0000_0000_1234_5678;
`endif

      // reset state of both instances
      repeat (2) @(negedge clock);
      check("rst a req_ready",  64'(a_req_ready),  64'd1);
      check("rst a resp_valid", 64'(a_resp_valid), 64'd0);
      check("rst a rdata",      a_resp_rdata,      64'd0);
      check("rst a err",        64'(a_resp_err),   64'd0);
      check("rst b req_ready",  64'(b_req_ready),  64'd1);
      check("rst b resp_valid", 64'(b_resp_valid), 64'd0);
      check("rst b rdata",      b_resp_rdata,      64'd0);
      check("rst b err",        64'(b_resp_err),   64'd0);
      reset = 1'b0;

      // reset while the LATENCY=4 store is still waiting
      sel4 = 1'b1;
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40; req_size = 2'd3;
      req_unsigned = 1'b0; req_wdata = 64'h1111;
      @(posedge clock); #1;
      req_valid = 1'b0; mon_en = 1'b1;
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      check("midwait rst valid", 64'(b_resp_valid), 64'd0);
      check("midwait rst ready", 64'(b_req_ready),  64'd1);
      @(negedge clock);
      reset = 1'b0;
      repeat (6) @(negedge clock);
      mon_en = 1'b0;
      check("midwait no resp", 64'(seen), 64'd0);
      do_req("midwait ld D 0x40", 1'b0, 64'h40, 2'd3, 1'b0, 64'h0, 64'h0, 1'b0, 0);

      // main sequence on the LATENCY=3 instance
      sel4 = 1'b0;
      do_req("st D 0x10",  1'b1, 64'h10, 2'd3, 1'b0, 64'h8877665544332211, 64'h0, 1'b0, 0);
      do_req("ld B s 0x17", 1'b0, 64'h17, 2'd0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 0);
      do_req("ld B u 0x17", 1'b0, 64'h17, 2'd0, 1'b1, 64'h0, 64'h0000_0000_0000_0088, 1'b0, 0);
      do_req("st H 0x12",  1'b1, 64'h12, 2'd1, 1'b0, 64'hDEAD_DEAD_DEAD_BEEF, 64'h0, 1'b0, 0);
      do_req("ld D 0x10 bp", 1'b0, 64'h10, 2'd3, 1'b1, 64'h0, 64'h88776655BEEF2211, 1'b0, 5);
      do_req("ld H s 0x12", 1'b0, 64'h12, 2'd1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 0);
      do_req("st W 0x800", 1'b1, 64'h800, 2'd2, 1'b0, 64'h0000_0000_CAFE_F00D, 64'h0, 1'b0, 0);
      do_req("ld W s 0x0", 1'b0, 64'h0, 2'd2, 1'b0, 64'h0, 64'hFFFF_FFFF_CAFE_F00D, 1'b0, 0);
      do_req("ld W u 0x0", 1'b0, 64'h0, 2'd2, 1'b1, 64'h0, 64'h0000_0000_CAFE_F00D, 1'b0, 0);
      do_req("st W mis 0x21", 1'b1, 64'h21, 2'd2, 1'b0, 64'h12345678, 64'h0, exp_err_mis, 0);
      do_req("ld W mis 0x21", 1'b0, 64'h21, 2'd2, 1'b0, 64'h0, exp_mis_ld, exp_err_mis, 0);
      do_req("ld D 0x20",  1'b0, 64'h20, 2'd3, 1'b0, 64'h0, exp_mis_word, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
